// File: rtl/sparse_window_sequencer.sv
// rtl/sparse_window_sequencer.sv - Sequences compressed transfer blocks of one sparse window to the buffer-update stage
module sparse_window_sequencer #(
    parameter int TRANSFER_SIZE           = 4,
    parameter int CLUSTER_BITWIDTH        = 8,
    parameter int COMPRESSION_WINDOW_SIZE = 32
) (
    input  logic                                                   clock,
    input  logic                                                   resetn,
    input  logic                                                   i_mask_valid,
    output logic                                                   o_mask_ready,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0]                     i_mask,
    input  logic                                                   i_block_valid,
    output logic                                                   o_block_ready,
    input  logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0]              i_block,
    output logic                                                   o_out_valid,
    input  logic                                                   i_out_ready,
    output logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0]              o_out_block,
    output logic [$clog2(COMPRESSION_WINDOW_SIZE/TRANSFER_SIZE)-1:0] o_out_index,
    output logic [$clog2(TRANSFER_SIZE):0]                         o_out_count,
    output logic                                                   o_out_last,
    output logic                                                   o_window_done
);

    localparam int INDEX_W = $clog2(COMPRESSION_WINDOW_SIZE / TRANSFER_SIZE);
    localparam int COUNT_W = $clog2(TRANSFER_SIZE) + 1;
    localparam int POP_W   = $clog2(COMPRESSION_WINDOW_SIZE + 1);
    localparam int NB_W    = $clog2((COMPRESSION_WINDOW_SIZE + TRANSFER_SIZE - 1) / TRANSFER_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } stateType;

    stateType           state;
    logic [NB_W-1:0]    counter;
    logic [NB_W-1:0]    numBlocks;
    logic [COUNT_W-1:0] rem;

    logic [POP_W-1:0]   popCount;
    logic [NB_W-1:0]    maskBlocks;
    logic [COUNT_W-1:0] maskRem;

    logic maskHs;
    logic blockHs;
    logic outHs;
    logic isLast;

    // Block acceptance is combinational on downstream ready so a full pipeline moves one block per cycle
    assign o_block_ready = (state == STREAM) && (!o_out_valid || i_out_ready);
    assign maskHs        = i_mask_valid && o_mask_ready;
    assign blockHs       = i_block_valid && o_block_ready;
    assign outHs         = o_out_valid && i_out_ready;
    assign isLast        = (counter == numBlocks - NB_W'(1));

    // Window geometry from the incoming bitmask: non-zero cluster count, block count, tail size
    always_comb begin
        popCount = '0;
        for (int i = 0; i < COMPRESSION_WINDOW_SIZE; i++) begin
            popCount = popCount + POP_W'(i_mask[i]);
        end
        maskBlocks = NB_W'((32'(popCount) + TRANSFER_SIZE - 1) / TRANSFER_SIZE);
        maskRem    = COUNT_W'(32'(popCount) % TRANSFER_SIZE);
    end

    // Window FSM plus output register; all outputs except o_block_ready are registered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            counter       <= '0;
            numBlocks     <= '0;
            rem           <= '0;
            o_mask_ready  <= 1'b0;
            o_out_valid   <= 1'b0;
            o_out_block   <= '0;
            o_out_index   <= '0;
            o_out_count   <= '0;
            o_out_last    <= 1'b0;
            o_window_done <= 1'b0;
        end else begin
            o_window_done <= 1'b0;

            // A new block replaces the register even when the old one leaves in the same cycle
            if (blockHs) begin
                o_out_valid <= 1'b1;
                o_out_block <= i_block;
                o_out_index <= INDEX_W'(counter);
                o_out_last  <= isLast;
                o_out_count <= (isLast && rem != '0) ? rem : COUNT_W'(TRANSFER_SIZE);
            end else if (outHs) begin
                o_out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    o_mask_ready <= 1'b1;
                    if (maskHs) begin
                        o_mask_ready <= 1'b0;
                        numBlocks    <= maskBlocks;
                        rem          <= maskRem;
                        counter      <= '0;
                        if (maskBlocks != '0) begin
                            state <= STREAM;
                        end else begin
                            state         <= DONE;
                            o_window_done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (blockHs) begin
                        counter <= counter + NB_W'(1);
                        if (isLast) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (outHs && o_out_last) begin
                        state         <= DONE;
                        o_window_done <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    o_mask_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_window_sequencer.sv
// tb/tb_sparse_window_sequencer.sv - Self-checking bench for sparse_window_sequencer
module tb_sparse_window_sequencer;

    localparam int TS  = 4;
    localparam int CB  = 8;
    localparam int CWS = 32;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic                i_mask_valid = 1'b0;
    logic                o_mask_ready;
    logic [CWS-1:0]      i_mask = '0;
    logic                i_block_valid = 1'b0;
    logic                o_block_ready;
    logic [TS*CB-1:0]    i_block = '0;
    logic                o_out_valid;
    logic                i_out_ready = 1'b0;
    logic [TS*CB-1:0]    o_out_block;
    logic [2:0]          o_out_index;
    logic [2:0]          o_out_count;
    logic                o_out_last;
    logic                o_window_done;

    sparse_window_sequencer #(
        .TRANSFER_SIZE(TS),
        .CLUSTER_BITWIDTH(CB),
        .COMPRESSION_WINDOW_SIZE(CWS)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .i_mask_valid(i_mask_valid),
        .o_mask_ready(o_mask_ready),
        .i_mask(i_mask),
        .i_block_valid(i_block_valid),
        .o_block_ready(o_block_ready),
        .i_block(i_block),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_block(o_out_block),
        .o_out_index(o_out_index),
        .o_out_count(o_out_count),
        .o_out_last(o_out_last),
        .o_window_done(o_window_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] blocks [16];

    typedef struct {
        logic [31:0] mask;
        int          readyMode;
        int          expOutputs;
        int          expLastCount;
    } vecType;

    vecType vectors [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input int k);
        logic [31:0] w;
        w = {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
        return w;
    endfunction

    // readyMode: 0 always ready, 1 random, 2 three-cycle stall once index 2 is presented
    // validMode: 0 block always offered, 1 random
    task automatic runWindow(input logic [31:0] mask, input int readyMode, input int validMode,
                             output int nOut, output int lastCount);
        int pop, n, rem, consumed, delivered, stallLeft, cyc, expCount;
        bit stallUsed, doneExp, finished, bv, rdy, expValid, expBR;
        pop = $countones(mask);
        n   = (pop + TS - 1) / TS;
        rem = pop % TS;
        nOut = 0;
        lastCount = 0;

        @(negedge clock);
        #1;
        cyc = 0;
        while (!o_mask_ready && cyc < 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("mask_ready_idle", 64'(o_mask_ready), 64'(1));
        i_mask        = mask;
        i_mask_valid  = 1'b1;
        i_block_valid = 1'b0;
        i_out_ready   = 1'b1;
        @(negedge clock);

        consumed  = 0;
        delivered = 0;
        stallLeft = 0;
        stallUsed = 1'b0;
        doneExp   = (n == 0);
        finished  = 1'b0;
        for (cyc = 0; cyc < 300 && !finished; cyc++) begin
            bv = (validMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (readyMode == 0) begin
                rdy = 1'b1;
            end else if (readyMode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end else if (stallLeft > 0) begin
                rdy = 1'b0;
                stallLeft--;
            end else if (!stallUsed && delivered == 2 && consumed > delivered) begin
                stallUsed = 1'b1;
                stallLeft = 2;
                rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            i_block_valid = bv;
            i_block       = blocks[consumed];
            i_out_ready   = rdy;
            i_mask_valid  = 1'($urandom_range(0, 1));
            i_mask        = $urandom;
            #1;
            expValid = (consumed > delivered);
            expBR    = (consumed < n) && (!expValid || rdy);
            check("out_valid", 64'(o_out_valid), 64'(expValid));
            check("block_ready", 64'(o_block_ready), 64'(expBR));
            check("mask_ready_busy", 64'(o_mask_ready), 64'(0));
            check("window_done", 64'(o_window_done), 64'(doneExp));
            if (expValid && o_out_valid) begin
                expCount = (delivered == n - 1 && rem != 0) ? rem : TS;
                check("out_block", 64'(o_out_block), 64'(blocks[delivered]));
                check("out_index", 64'(o_out_index), 64'(delivered));
                check("out_count", 64'(o_out_count), 64'(expCount));
                check("out_last", 64'(o_out_last), 64'(delivered == n - 1));
            end
            if (doneExp) finished = 1'b1;
            if (bv && expBR) consumed++;
            doneExp = 1'b0;
            if (expValid && rdy) begin
                nOut++;
                if (o_out_last) lastCount = int'(o_out_count);
                delivered++;
                doneExp = (delivered == n);
            end
            @(negedge clock);
        end
        if (!finished) check("window_timeout", 64'(0), 64'(1));
        i_mask_valid  = 1'b0;
        i_block_valid = 1'b0;
        #1;
        check("mask_ready_after_done", 64'(o_mask_ready), 64'(1));
        check("window_done_single", 64'(o_window_done), 64'(0));
    endtask

    initial begin
        int nOut, lastCount, cyc, n;
        logic [31:0] mask;

        vectors[0] = '{32'hFFFF_FFFF, 0, 8, 4};
        vectors[1] = '{32'hF00F_F00F, 0, 4, 4};
        vectors[2] = '{32'h0000_0007, 0, 1, 3};
        vectors[3] = '{32'h0000_0000, 0, 0, 0};
        vectors[4] = '{32'hFFFF_FFFF, 2, 8, 4};
        vectors[5] = '{32'h8001_0421, 1, 2, 1};

        for (int k = 0; k < 16; k++) blocks[k] = pattern(k);

        #12;
        check("reset_mask_ready", 64'(o_mask_ready), 64'(0));
        check("reset_block_ready", 64'(o_block_ready), 64'(0));
        check("reset_out_valid", 64'(o_out_valid), 64'(0));
        check("reset_window_done", 64'(o_window_done), 64'(0));
        @(negedge clock);
        resetn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            runWindow(vectors[v].mask, vectors[v].readyMode, 0, nOut, lastCount);
            check($sformatf("vec%0d_outputs", v), 64'(nOut), 64'(vectors[v].expOutputs));
            check($sformatf("vec%0d_last_count", v), 64'(lastCount), 64'(vectors[v].expLastCount));
        end

        // Reset in the middle of a full window, then a fresh window
        @(negedge clock);
        i_mask = 32'hFFFF_FFFF;
        i_mask_valid = 1'b1;
        @(negedge clock);
        i_mask_valid  = 1'b0;
        i_block_valid = 1'b1;
        i_out_ready   = 1'b1;
        cyc = 0;
        i_block = blocks[0];
        #1;
        while (!(o_out_valid && o_out_index == 3'd3) && cyc < 20) begin
            @(posedge clock);
            @(negedge clock);
            i_block = blocks[cyc + 1];
            #1;
            cyc++;
        end
        check("reach_index3", 64'(o_out_index), 64'(3));
        #2;
        resetn = 1'b0;
        #1;
        check("rst_out_valid", 64'(o_out_valid), 64'(0));
        check("rst_out_block", 64'(o_out_block), 64'(0));
        check("rst_out_index", 64'(o_out_index), 64'(0));
        check("rst_out_count", 64'(o_out_count), 64'(0));
        check("rst_out_last", 64'(o_out_last), 64'(0));
        check("rst_window_done", 64'(o_window_done), 64'(0));
        check("rst_block_ready", 64'(o_block_ready), 64'(0));
        check("rst_mask_ready", 64'(o_mask_ready), 64'(0));
        i_block_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        runWindow(32'h0000_000F, 0, 0, nOut, lastCount);
        check("post_reset_outputs", 64'(nOut), 64'(1));
        check("post_reset_last_count", 64'(lastCount), 64'(4));

        // Randomized windows with random backpressure and block availability
        for (int w = 0; w < 30; w++) begin
            for (int k = 0; k < 16; k++) blocks[k] = $urandom;
            case ($urandom_range(0, 3))
                0:       mask = $urandom;
                1:       mask = $urandom & $urandom & $urandom;
                2:       mask = 32'hFFFF_FFFF;
                default: mask = 32'(1) << $urandom_range(0, 31);
            endcase
            n = ($countones(mask) + TS - 1) / TS;
            runWindow(mask, 1, 1, nOut, lastCount);
            check("rand_outputs", 64'(nOut), 64'(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
